// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the OpenRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 22;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_RAM_DEPTH  = 1 << DEFAULT_ADDR_WIDTH;
    localparam int OUTQ_DEPTH         = 2;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0]     ptr_t;
    typedef logic [DEFAULT_ADDR_WIDTH:0]       count_t;
    typedef logic [$clog2(OUTQ_DEPTH+1)-1:0]   outq_count_t;

endpackage

// File: rtl/sram_fifo_outq.sv
// Two-entry output queue that holds words read back from the macro.
// Entry 0 is always the head; a pop shifts entry 1 forward.
module sram_fifo_outq
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output outq_count_t           count
);

    localparam outq_count_t ONE = outq_count_t'(1);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    assign head = entry0;

    // Pop is only ever asserted with count != 0, and capture never arrives with the queue full.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            unique case ({capture, pop})
                2'b10: begin
                    if (count == '0) begin
                        entry0 <= capture_data;
                    end else begin
                        entry1 <= capture_data;
                    end
                    count <= count + ONE;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - ONE;
                end
                2'b11: begin
                    if (count == ONE) begin
                        entry0 <= capture_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= capture_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO built on a 0rw1r1w OpenRAM macro (write port 0, read port 1).
// Optional macro SRAM_FIFO_CTRL_LEVEL_EN adds a registered fill-level output and sanity checks.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level
`endif
);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = RAM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   committed;
    logic [ADDR_WIDTH:0]   committed_next;
    logic [ADDR_WIDTH:0]   sram_used;
    logic [ADDR_WIDTH:0]   sram_used_next;
    logic                  inflight;
    logic                  accept;
    logic                  issue;
    logic                  pop_fire;
    logic [2:0]            occupancy;
    outq_count_t           outq_count;
    logic [DATA_WIDTH-1:0] outq_head;

    assign push_ready = !rst && (sram_used < FULL_LEVEL);
    assign accept     = push_valid && push_ready;
    assign pop_valid  = !rst && (outq_count != '0);
    assign pop_fire   = pop_valid && pop_ready;
    assign occupancy  = {1'b0, outq_count} + {2'b00, inflight};

    // Counting this cycle's pop as free space lets the queue stream one word per cycle.
    assign issue = !rst && (committed != '0)
                 && ((occupancy < 3'd2) || (pop_fire && (occupancy == 3'd2)));

    assign csb0     = !accept;
    assign addr0    = wptr;
    assign din0     = push_data;
    assign csb1     = !issue;
    assign addr1    = rptr;
    assign pop_data = outq_head;

    // Both counters lag by a cycle so a slot is never written and read on the same negedge.
    always_comb begin
        committed_next = committed;
        sram_used_next = sram_used;
        if (accept) begin
            committed_next = committed_next + CNT_ONE;
            sram_used_next = sram_used_next + CNT_ONE;
        end
        if (issue) begin
            committed_next = committed_next - CNT_ONE;
        end
        if (inflight) begin
            sram_used_next = sram_used_next - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            committed <= '0;
            sram_used <= '0;
            inflight  <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (issue) begin
                rptr <= rptr + PTR_ONE;
            end
            committed <= committed_next;
            sram_used <= sram_used_next;
            inflight  <= issue;
        end
    end

    sram_fifo_outq #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outq (
        .clk         (clk),
        .rst         (rst),
        .capture     (inflight),
        .capture_data(dout1),
        .pop         (pop_fire),
        .head        (outq_head),
        .count       (outq_count)
    );

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= {1'b0, sram_used} + {{ADDR_WIDTH{1'b0}}, outq_count};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept && (sram_used == FULL_LEVEL)));
            assert (!(pop_fire && (outq_count == '0)));
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized scoreboard bench for sram_fifo_ctrl with a behavioural 0rw1r1w macro model.
module tb_sram_fifo_ctrl;
   import sram_fifo_pkg::*;

   localparam int DW = DEFAULT_DATA_WIDTH;
   localparam int AW = DEFAULT_ADDR_WIDTH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push_valid = 1'b0;
   logic          push_ready;
   logic [DW-1:0] push_data = '0;
   logic          pop_valid;
   logic          pop_ready = 1'b0;
   logic [DW-1:0] pop_data;
   logic          csb0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic          csb1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] dout1;
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
   logic [AW+1:0] level;
`endif

   int errors = 0;
   int checks = 0;
   int pop_count = 0;
   int cyc = 0;

   logic [DW-1:0] exp_q[$];
   ptr_t          exp_waddr = '0;
   ptr_t          exp_raddr = '0;

   sram_fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .push_valid(push_valid),
      .push_ready(push_ready),
      .push_data (push_data),
      .pop_valid (pop_valid),
      .pop_ready (pop_ready),
      .pop_data  (pop_data),
      .csb0      (csb0),
      .addr0     (addr0),
      .din0      (din0),
      .csb1      (csb1),
      .addr1     (addr1),
      .dout1     (dout1)
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
      ,
      .level     (level)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Macro model: ports sampled at posedge, array accessed on the following negedge.
   logic [DW-1:0] mem [DEFAULT_RAM_DEPTH];
   logic          l_we = 1'b0;
   logic          l_re = 1'b0;
   logic [AW-1:0] l_wa = '0;
   logic [AW-1:0] l_ra = '0;
   logic [DW-1:0] l_wd = '0;

   always @(posedge clk) begin
      l_we <= !csb0;
      l_wa <= addr0;
      l_wd <= din0;
      l_re <= !csb1;
      l_ra <= addr1;
   end

   always @(negedge clk) begin
      if (l_we) mem[l_wa] <= l_wd;
      if (l_re) dout1 <= mem[l_ra];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd, input logic pr);
      @(posedge clk);
      #1;
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
      @(negedge clk);
      #1;
   endtask

   // Scoreboard monitor: model of ordered storage and sequential macro addressing.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            exp_waddr = '0;
            exp_raddr = '0;
         end else begin
            if (push_valid && push_ready) begin
               checkOutput("csb0Low", 32'(csb0), 0);
               checkOutput("addr0", 32'(addr0), 32'(exp_waddr));
               checkOutput("din0", 32'(din0), 32'(push_data));
               exp_q.push_back(push_data);
               exp_waddr = ptr_t'(exp_waddr + 1);
            end else begin
               checkOutput("csb0High", 32'(csb0), 1);
            end
            if (!csb1) begin
               checkOutput("addr1", 32'(addr1), 32'(exp_raddr));
               exp_raddr = ptr_t'(exp_raddr + 1);
            end
            if (l_we && l_re) checkOutput("rdWrAddrDiffer", 32'(l_wa != l_ra), 1);
            if (pop_valid && pop_ready) begin
               pop_count++;
               if (exp_q.size() == 0) checkOutput("popEmptyModel", 32'(pop_valid), 0);
               else checkOutput("popData", 32'(pop_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic drain(input int n);
      int start;
      start = pop_count;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("drainCount", 32'(pop_count - start), 32'(n));
      checkOutput("drainEmpty", 32'(pop_valid), 0);
   endtask

   task automatic resetCycle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      push_valid = 1'b0;
      pop_ready = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rstPushReady", 32'(push_ready), 0);
      checkOutput("rstCsb0", 32'(csb0), 1);
      checkOutput("rstCsb1", 32'(csb1), 1);
      checkOutput("rstPopValid", 32'(pop_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("postRstPopValid", 32'(pop_valid), 0);
      checkOutput("postRstPopData", 32'(pop_data), 0);
      checkOutput("postRstCsb0", 32'(csb0), 1);
      checkOutput("postRstCsb1", 32'(csb1), 1);
      checkOutput("postRstPushReady", 32'(push_ready), 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin : stimulus
      int first_push;
      int first_valid;
      int n;
      int start;
      int first_pop;
      int last_pop;

      resetCycle();

      // Five words held back, then released in order.
      first_push = -1;
      first_valid = -1;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, DW'(i), 1'b0);
         if (push_ready && first_push < 0) first_push = cyc;
         if (pop_valid && first_valid < 0) first_valid = cyc;
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b0);
         if (pop_valid && first_valid < 0) first_valid = cyc;
      end
      checkOutput("firstPopLatency", 32'(first_valid >= 0 && first_valid >= first_push + 3), 1);
      drain(5);

      // Fill to capacity: 32 resident words plus 2 in the output queue.
      n = 0;
      for (int c = 0; c < 45; c++) begin
         applyStimulus(1'b1, DW'(n), 1'b0);
         if (push_ready) n++;
      end
      checkOutput("fullAccepts", 32'(n), 34);
      checkOutput("fullPushReady", 32'(push_ready), 0);
      drain(34);

      // Continuous streaming of 100 random words.
      n = 0;
      start = pop_count;
      first_pop = -1;
      last_pop = -1;
      for (int c = 0; c < 400 && (pop_count - start) < 100; c++) begin
         applyStimulus(n < 100, DW'($urandom), 1'b1);
         if (n < 100 && push_ready) n++;
         if (pop_valid) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
      end
      checkOutput("streamPops", 32'(pop_count - start), 100);
      checkOutput("streamGapless", 32'(last_pop - first_pop + 1), 100);
      drain(0);

      // Random traffic, push-heavy then pop-heavy.
      for (int c = 0; c < 300; c++) begin
         if (c < 150) applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0);
         else applyStimulus($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) != 0);
      end
      drain(exp_q.size());

      // Write-to-read spacing on an empty FIFO.
      applyStimulus(1'b1, 22'h2AAAAA, 1'b0);
      checkOutput("wrCycleCsb1", 32'(csb1), 1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("nextCycleCsb1", 32'(csb1), 0);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("patValid", 32'(pop_valid), 1);
      checkOutput("patData", 32'(pop_data), 32'h2AAAAA);
      drain(1);

      // Reset with ten words stored and a read in flight.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("setupReadIssued", 32'(csb1), 0);
      resetCycle();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("staleReadDropped", 32'(pop_valid), 0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
      drain(7);

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
      checkOutput("level3", 32'(level), 3);
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
      checkOutput("level2", 32'(level), 2);
      drain(2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
